// File: rtl/cla16_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cla16_pipe
//  Function : Two-stage pipelined 16-bit carry-lookahead adder (4 x 4-bit
//             groups) with valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module cla16_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] sum,
   output logic        c_out,
   output logic        ovf,
   output logic        P,
   output logic        G
);

   localparam int c_GROUPS = 4;
   localparam int c_GW     = 4;

   // ------------------------------------------------------------------------
   // Stage 1: per-bit generate/propagate and group P/G
   // ------------------------------------------------------------------------
   logic [15:0]         w_s1_g;
   logic [15:0]         w_s1_p;
   logic [c_GROUPS-1:0] w_s1_gp;
   logic [c_GROUPS-1:0] w_s1_gg;

   assign w_s1_g = a & b;
   assign w_s1_p = a | b;

   generate
      for (genvar k = 0; k < c_GROUPS; k++) begin : g_s1_grp
         logic [c_GW-1:0] w_gi;
         logic [c_GW-1:0] w_pi;

         assign w_gi = w_s1_g[k*c_GW +: c_GW];
         assign w_pi = w_s1_p[k*c_GW +: c_GW];

         assign w_s1_gp[k] = &w_pi;
         assign w_s1_gg[k] = w_gi[3]
                           | (w_pi[3] & w_gi[2])
                           | (w_pi[3] & w_pi[2] & w_gi[1])
                           | (w_pi[3] & w_pi[2] & w_pi[1] & w_gi[0]);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Handshake: a stage moves when empty or when its successor drains it
   // ------------------------------------------------------------------------
   logic                r_s1_valid;
   logic [15:0]         r_s1_a;
   logic [15:0]         r_s1_b;
   logic                r_s1_cin;
   logic [c_GROUPS-1:0] r_s1_gp;
   logic [c_GROUPS-1:0] r_s1_gg;

   logic w_s2_advance;
   logic w_s1_advance;
   logic w_in_fire;
   logic w_s1_fire;

   assign w_s2_advance = !out_valid | out_ready;
   assign w_s1_advance = !r_s1_valid | w_s2_advance;
   assign in_ready     = w_s1_advance;
   assign w_in_fire    = in_valid & w_s1_advance;
   assign w_s1_fire    = r_s1_valid & w_s2_advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_cin   <= 1'b0;
         r_s1_gp    <= '0;
         r_s1_gg    <= '0;
      end else begin
         if (w_s1_advance) begin
            r_s1_valid <= in_valid;
         end
         if (w_in_fire) begin
            r_s1_a   <= a;
            r_s1_b   <= b;
            r_s1_cin <= c_in;
            r_s1_gp  <= w_s1_gp;
            r_s1_gg  <= w_s1_gg;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: second-level lookahead for group carries
   // ------------------------------------------------------------------------
   logic [c_GROUPS:0] w_gc;
   logic              w_blk_p;
   logic              w_blk_g;

   assign w_gc[0] = r_s1_cin;
   assign w_gc[1] = r_s1_gg[0]
                  | (r_s1_gp[0] & r_s1_cin);
   assign w_gc[2] = r_s1_gg[1]
                  | (r_s1_gp[1] & r_s1_gg[0])
                  | (r_s1_gp[1] & r_s1_gp[0] & r_s1_cin);
   assign w_gc[3] = r_s1_gg[2]
                  | (r_s1_gp[2] & r_s1_gg[1])
                  | (r_s1_gp[2] & r_s1_gp[1] & r_s1_gg[0])
                  | (r_s1_gp[2] & r_s1_gp[1] & r_s1_gp[0] & r_s1_cin);
   assign w_gc[4] = w_blk_g
                  | (w_blk_p & r_s1_cin);

   assign w_blk_p = &r_s1_gp;
   assign w_blk_g = r_s1_gg[3]
                  | (r_s1_gp[3] & r_s1_gg[2])
                  | (r_s1_gp[3] & r_s1_gp[2] & r_s1_gg[1])
                  | (r_s1_gp[3] & r_s1_gp[2] & r_s1_gp[1] & r_s1_gg[0]);

   // In-group carries are rebuilt from the registered operands rather than
   // carrying 32 extra g/p flops through the stage-1 register.
   logic [15:0] w_s2_g;
   logic [15:0] w_s2_p;
   logic [15:0] w_s2_x;
   logic [15:0] w_carry;
   logic [15:0] w_sum;
   logic        w_ovf;

   assign w_s2_g = r_s1_a & r_s1_b;
   assign w_s2_p = r_s1_a | r_s1_b;
   assign w_s2_x = r_s1_a ^ r_s1_b;

   generate
      for (genvar k = 0; k < c_GROUPS; k++) begin : g_s2_grp
         logic [c_GW-1:0] w_gi;
         logic [c_GW-1:0] w_pi;
         logic            w_ci;

         assign w_gi = w_s2_g[k*c_GW +: c_GW];
         assign w_pi = w_s2_p[k*c_GW +: c_GW];
         assign w_ci = w_gc[k];

         assign w_carry[k*c_GW + 0] = w_ci;
         assign w_carry[k*c_GW + 1] = w_gi[0]
                                    | (w_pi[0] & w_ci);
         assign w_carry[k*c_GW + 2] = w_gi[1]
                                    | (w_pi[1] & w_gi[0])
                                    | (w_pi[1] & w_pi[0] & w_ci);
         assign w_carry[k*c_GW + 3] = w_gi[2]
                                    | (w_pi[2] & w_gi[1])
                                    | (w_pi[2] & w_pi[1] & w_gi[0])
                                    | (w_pi[2] & w_pi[1] & w_pi[0] & w_ci);
      end
   endgenerate

   assign w_sum = w_s2_x ^ w_carry;
   assign w_ovf = w_carry[15] ^ w_gc[4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         P         <= 1'b0;
         G         <= 1'b0;
      end else begin
         if (w_s2_advance) begin
            out_valid <= r_s1_valid;
         end
         if (w_s1_fire) begin
            sum   <= w_sum;
            c_out <= w_gc[4];
            ovf   <= w_ovf;
            P     <= w_blk_p;
            G     <= w_blk_g;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cla16_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla16_pipe
//  Function : Directed and randomised self-checking bench for cla16_pipe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cla16_pipe;

   localparam int c_N_RAND = 2000;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        in_ready;
   logic [15:0] a         = '0;
   logic [15:0] b         = '0;
   logic        c_in      = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] sum;
   logic        c_out;
   logic        ovf;
   logic        P;
   logic        G;
   logic [19:0] res;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cla16_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf),
      .P         (P),
      .G         (G)
   );

   // {c_out, ovf, P, G, sum}
   assign res = {c_out, ovf, P, G, sum};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
      in_valid = 1'b1;
      a        = ta;
      b        = tb;
      c_in     = tc;
   endtask

   function automatic logic [19:0] ref_res(input logic [15:0] x, input logic [15:0] y,
                                           input logic ci);
      logic [16:0] s;
      logic [15:0] lo;
      logic [16:0] gs;
      s  = {1'b0, x} + {1'b0, y} + {16'b0, ci};
      lo = {1'b0, x[14:0]} + {1'b0, y[14:0]} + {15'b0, ci};
      gs = {1'b0, x} + {1'b0, y};
      return {s[16], lo[15] ^ s[16], &(x | y), gs[16], s[15:0]};
   endfunction

   logic [19:0] exp_q[$];
   int          sent;
   int          cyc;
   logic        acc;

   initial begin
      // reset state, before any clock edge
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      step();
      step();
      rst_n = 1'b1;

      // wrap, first beat after reset: 2-cycle latency
      drive(16'hFFFF, 16'h0001, 1'b0);
      #1;
      chk("wrap_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("wrap_lat1_valid", 32'(out_valid), 32'd0);
      step();
      chk("wrap_valid", 32'(out_valid), 32'd1);
      chk("wrap_res", 32'(res), 32'h0_B0000);
      step();
      chk("wrap_gone", 32'(out_valid), 32'd0);

      // plain add and signed overflow back-to-back
      drive(16'h1234, 16'h4321, 1'b1);
      step();
      drive(16'h7FFF, 16'h0001, 1'b0);
      step();
      in_valid = 1'b0;
      chk("plain_valid", 32'(out_valid), 32'd1);
      chk("plain_res", 32'(res), 32'h0_05556);
      step();
      chk("sovf_valid", 32'(out_valid), 32'd1);
      chk("sovf_res", 32'(res), 32'h0_48000);
      step();
      chk("b2b_gone", 32'(out_valid), 32'd0);

      // back-pressure: four beats with out_ready held low
      out_ready = 1'b0;
      drive(16'h0001, 16'h0001, 1'b0);
      step();
      drive(16'h8000, 16'h8000, 1'b0);
      step();
      drive(16'h00FF, 16'h0001, 1'b1);
      #1;
      chk("bp_full_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_res0", 32'(res), 32'h0_00002);
      step();
      chk("bp_full_in_ready2", 32'(in_ready), 32'd0);
      chk("bp_hold_res1", 32'(res), 32'h0_00002);
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("bp_res1", 32'(res), 32'h0_D0000);
      drive(16'hFFFF, 16'hFFFF, 1'b1);
      step();
      in_valid = 1'b0;
      chk("bp_res2", 32'(res), 32'h0_00101);
      step();
      chk("bp_res3_valid", 32'(out_valid), 32'd1);
      chk("bp_res3", 32'(res), 32'h0_BFFFF);
      step();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // reset with two beats in flight
      out_ready = 1'b0;
      drive(16'h1111, 16'h2222, 1'b0);
      step();
      drive(16'h3333, 16'h4444, 1'b1);
      step();
      in_valid = 1'b0;
      chk("mid_pre_valid", 32'(out_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_res", 32'(res), 32'd0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mid_no_stale", 32'(out_valid), 32'd0);
      end
      drive(16'h1234, 16'h4321, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      chk("mid_after_valid", 32'(out_valid), 32'd1);
      chk("mid_after_res", 32'(res), 32'h0_05556);

      // random traffic against a behavioural model
      sent = 0;
      cyc  = 0;
      acc  = 1'b0;
      while ((sent < c_N_RAND || exp_q.size() != 0) && cyc < 20000) begin
         step();
         cyc++;
         if (acc) in_valid = 1'b0;
         if (!in_valid && sent < c_N_RAND && $urandom_range(3) != 0) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom));
         end
         out_ready = ($urandom_range(3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("rnd_extra", 32'(out_valid), 32'd0);
            else                   chk("rnd_res", 32'(res), 32'(exp_q.pop_front()));
         end
         acc = in_valid && in_ready;
         if (acc) begin
            exp_q.push_back(ref_res(a, b, c_in));
            sent++;
         end
      end
      in_valid = 1'b0;
      chk("rnd_sent", 32'(sent), 32'(c_N_RAND));
      chk("rnd_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
